// File: rtl/multiword_add_seq.sv
// Multi-limb adder/subtractor: one 16-bit prefix adder is stepped across WORDS
// limbs, LSB limb first, with the inter-limb carry held in a register.

module prefix_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] g, p, gk, pk;

    // Kogge-Stone: carry-in is folded into bit 0's generate so the tree yields all carries
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        gk    = g;
        pk    = p;
        gk[0] = g[0] | (p[0] & ci);
        for (int d = 1; d < 16; d = d * 2) begin
            // descending order keeps lower bits at the previous level's values
            for (int i = 15; i >= d; i--) begin
                gk[i] = gk[i] | (pk[i] & gk[i-d]);
                pk[i] = pk[i] & pk[i-d];
            end
        end
        s  = p ^ {gk[14:0], ci};
        co = gk[15];
    end
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [W-1:0]       a_reg, b_reg, sum_reg;
    logic [W+15:0]      sum_cat;
    logic               carry, op_reg, cout_reg, ovf_reg;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [15:0]        add_s;
    logic               add_co;

    prefix_add16 u_add (
        .a  (a_reg[15:0]),
        .b  (b_reg[15:0]),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    assign last    = (idx == IDX_W'(WORDS - 1));
    // new limb enters at the top; after WORDS shifts limb 0 sits in bits [15:0]
    assign sum_cat = {add_s, sum_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            op_reg   <= 1'b0;
            idx      <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // subtraction is A + ~B + ~borrow
                    a_reg  <= a;
                    b_reg  <= op_sub ? ~b : b;
                    op_reg <= op_sub;
                    carry  <= op_sub ^ cin;
                    idx    <= '0;
                end
                RUN: begin
                    a_reg   <= a_reg >> 16;
                    b_reg   <= b_reg >> 16;
                    sum_reg <= sum_cat[W+15:16];
                    carry   <= add_co;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        ovf_reg  <= (a_reg[15] == b_reg[15]) && (add_s[15] != a_reg[15]);
                        cout_reg <= op_reg ^ add_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
endmodule
